// File: rtl/lab_lut_pkg.sv
// Shared types and helpers for the programmable LUT bank: sweep FSM states,
// table-size derivation and the single bit-select lookup used by every reader.
package lab_lut_pkg;

    typedef enum logic {IDLE, SWEEP} lut_state_t;

    localparam int LUT_MAX_IN = 6;
    localparam int LUT_MAX_T  = 64;

    function automatic int lut_width(input int n_in);
        return 1 << n_in;
    endfunction

    function automatic int lut_chan_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    // Callers zero-extend to the maximum table size so one function serves every N_IN.
    function automatic logic lut_lookup(input logic [LUT_MAX_T-1:0] tbl,
                                        input logic [LUT_MAX_IN-1:0] idx);
        return tbl[idx];
    endfunction

endpackage

// File: rtl/lab_lut_cell.sv
// One channel's truth table: synchronous write of the whole table,
// combinational read of a single bit at an N_IN-bit index.
module lab_lut_cell
    import lab_lut_pkg::*;
#(
    parameter  int N_IN = 3,
    localparam int T    = lut_width(N_IN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [T-1:0]    wdata,
    input  logic [N_IN-1:0] idx,
    output logic            rd,
    output logic [T-1:0]    tbl
);

    logic [T-1:0] tbl_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            tbl_reg <= '0;
        end else if (we) begin
            tbl_reg <= wdata;
        end
    end

    assign tbl = tbl_reg;
    assign rd  = lut_lookup(LUT_MAX_T'(tbl_reg), LUT_MAX_IN'(idx));

endmodule

// File: rtl/lab_lut_bank.sv
// Bank of CHANNELS run-time programmable LUTs with registered parallel
// evaluation and a self-test sweep that reads back one channel's truth table.
module lab_lut_bank
    import lab_lut_pkg::*;
#(
    parameter  int N_IN     = 3,
    parameter  int CHANNELS = 2,
    localparam int T        = lut_width(N_IN),
    localparam int CW       = lut_chan_width(CHANNELS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [CW-1:0]            cfg_chan,
    input  logic [T-1:0]             cfg_table,
    input  logic                     in_valid,
    input  logic [CHANNELS*N_IN-1:0] in_data,
    output logic                     out_valid,
    output logic [CHANNELS-1:0]      out_data,
    input  logic                     sweep_start,
    input  logic [CW-1:0]            sweep_chan,
    output logic                     busy,
    output logic                     sweep_done,
    output logic [T-1:0]             sweep_table
);

    localparam logic [CW:0]   CH_LIM   = (CW+1)'(CHANNELS);
    localparam logic [N_IN:0] CNT_LAST = (N_IN+1)'(T - 1);

    lut_state_t          state_reg, state_next;
    logic [CW-1:0]       chan_reg, chan_next;
    logic [N_IN:0]       cnt_reg, cnt_next;
    logic [T-1:0]        sweep_table_reg;
    logic                sweep_done_reg;
    logic                out_valid_reg;
    logic [CHANNELS-1:0] out_data_reg;

    logic [CHANNELS-1:0] rd_bits;
    logic [CHANNELS-1:0] cell_we;
    logic [T-1:0]        tbl_all [CHANNELS];
    logic                cfg_accept;
    logic                start_ok;
    logic                last_step;
    logic                sweep_bit;

    assign cfg_ready  = (state_reg == IDLE) && !rst;
    assign cfg_accept = cfg_valid && cfg_ready;
    assign start_ok   = sweep_start && ({1'b0, sweep_chan} < CH_LIM);
    assign last_step  = (cnt_reg == CNT_LAST);
    assign sweep_bit  = lut_lookup(LUT_MAX_T'(tbl_all[chan_reg]),
                                   LUT_MAX_IN'(cnt_reg[N_IN-1:0]));

    // An out-of-range cfg_chan matches no cell, so the handshake completes without a write.
    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_cell
            assign cell_we[gi] = cfg_accept && (cfg_chan == CW'(gi));

            lab_lut_cell #(.N_IN(N_IN)) u_cell (
                .clk   (clk),
                .rst   (rst),
                .we    (cell_we[gi]),
                .wdata (cfg_table),
                .idx   (in_data[gi*N_IN +: N_IN]),
                .rd    (rd_bits[gi]),
                .tbl   (tbl_all[gi])
            );
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        chan_next  = chan_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (start_ok) begin
                    state_next = SWEEP;
                    chan_next  = sweep_chan;
                    cnt_next   = '0;
                end
            end
            SWEEP: begin
                cnt_next = cnt_reg + (N_IN+1)'(1);
                if (last_step) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            chan_reg  <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            chan_reg  <= chan_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Sweep starting alongside a config write reads the new table: the first lookup is a cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            sweep_table_reg <= '0;
            sweep_done_reg  <= 1'b0;
            out_valid_reg   <= 1'b0;
            out_data_reg    <= '0;
        end else begin
            sweep_done_reg <= (state_reg == SWEEP) && last_step;
            if (state_reg == SWEEP) begin
                sweep_table_reg[cnt_reg[N_IN-1:0]] <= sweep_bit;
            end
            out_valid_reg <= in_valid;
            if (in_valid) begin
                out_data_reg <= rd_bits;
            end
        end
    end

    assign busy        = (state_reg == SWEEP);
    assign sweep_done  = sweep_done_reg;
    assign sweep_table = sweep_table_reg;
    assign out_valid   = out_valid_reg;
    assign out_data    = out_data_reg;

endmodule
